// File: rtl/bmc_pkg.sv
// Shared types for the BMC frame sequencer: block width, FSM state encodings and the decoded beat.
package bmc_pkg;

    localparam int BLOCK_W = 24;

    typedef enum logic {
        HUNT,
        COLLECT
    } rx_state_t;

    typedef enum logic {
        ISSUE_IDLE,
        WAIT_DEC
    } iss_state_t;

    typedef struct packed {
        logic [BLOCK_W-1:0] data;
        logic               last;
    } dec_beat_t;

    localparam int BEAT_W = $bits(dec_beat_t);

endpackage

// File: rtl/bmc_beat_fifo.sv
// Two-entry beat buffer; a push into a full buffer is accepted only when a pop frees a slot that cycle.
module bmc_beat_fifo
    import bmc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BEAT_W-1:0] din,
    input  logic              pop,
    output logic [BEAT_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    dec_beat_t   mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        pop_en;
    logic        push_en;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= dec_beat_t'(din);
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bmc_frame_sequencer.sv
// Hunts a half-bit stream for the sync preamble, packs blocks, issues them to bmc_decoder one at a
// time and buffers the decoded beats for the consumer, flagging overrun and decoder-timeout faults.
module bmc_frame_sequencer
    import bmc_pkg::*;
#(
    parameter logic [7:0] SYNC_PAT    = 8'hE8,
    parameter int         BLK_PER_FRM = 4,
    parameter int         DEC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hb_in,
    input  logic        hb_valid,
    output logic [23:0] dec_i_block,
    output logic        dec_valid_in,
    input  logic [23:0] dec_o_block,
    input  logic        dec_valid_out,
    output logic [23:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        locked,
    output logic        err_overrun,
    output logic        err_timeout,
    output logic [15:0] frame_count
);

    localparam int BCNT_W = (BLK_PER_FRM > 1) ? $clog2(BLK_PER_FRM) : 1;
    localparam int HCNT_W = $clog2(BLOCK_W);
    localparam int TMO_W  = $clog2(DEC_TIMEOUT + 1);

    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(BLK_PER_FRM - 1);
    localparam logic [HCNT_W-1:0] HB_LAST  = HCNT_W'(BLOCK_W - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(DEC_TIMEOUT - 1);

    rx_state_t          rx_state;
    iss_state_t         iss_state;
    logic [6:0]         hunt_hist;
    logic [BLOCK_W-2:0] sreg;
    logic [HCNT_W-1:0]  hb_cnt;
    logic [BCNT_W-1:0]  blk_cnt;
    logic [BLOCK_W-1:0] stage;
    logic               stage_vld;
    logic               stage_last;
    logic [BLOCK_W-1:0] hold;
    logic               hold_last;
    logic               hold_full;
    logic               cur_last;
    logic [TMO_W-1:0]   tmo;

    logic [7:0]         hunt_nxt;
    logic [BLOCK_W-1:0] sreg_nxt;
    logic               lock_now;
    logic               issue;
    logic               hold_drop;
    logic               push_req;
    logic               pop;
    logic               push_ok;
    logic               tmo_hit;
    logic               last_end;

    dec_beat_t          push_beat;
    dec_beat_t          head;
    logic [BEAT_W-1:0]  head_raw;
    logic               fifo_full;
    logic               fifo_empty;

    assign hunt_nxt  = {hunt_hist, hb_in};
    assign sreg_nxt  = {sreg, hb_in};
    assign lock_now  = (rx_state == HUNT) && hb_valid && (hunt_nxt == SYNC_PAT);
    assign issue     = (iss_state == ISSUE_IDLE) && hold_full;
    assign hold_drop = stage_vld && hold_full && !issue;
    assign push_req  = (iss_state == WAIT_DEC) && dec_valid_out;
    assign pop       = m_valid && m_ready;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign tmo_hit   = (iss_state == WAIT_DEC) && !dec_valid_out && (tmo == TMO_MAX);
    // The frame ends when its last block reaches the buffer, or is lost on the way there.
    assign last_end  = (hold_drop && stage_last) || (push_req && cur_last);

    always_comb begin
        push_beat      = '0;
        push_beat.data = dec_o_block;
        push_beat.last = cur_last;
    end

    assign head    = dec_beat_t'(head_raw);
    assign m_valid = !fifo_empty;
    assign m_data  = head.data;
    assign m_last  = head.last;

    bmc_beat_fifo u_beat_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= HUNT;
            iss_state    <= ISSUE_IDLE;
            hunt_hist    <= '0;
            sreg         <= '0;
            hb_cnt       <= '0;
            blk_cnt      <= '0;
            stage        <= '0;
            stage_vld    <= 1'b0;
            stage_last   <= 1'b0;
            hold         <= '0;
            hold_last    <= 1'b0;
            hold_full    <= 1'b0;
            cur_last     <= 1'b0;
            tmo          <= '0;
            dec_i_block  <= '0;
            dec_valid_in <= 1'b0;
            locked       <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
            frame_count  <= '0;
        end else begin
            dec_valid_in <= 1'b0;
            stage_vld    <= 1'b0;

            case (rx_state)
                HUNT: begin
                    if (hb_valid) begin
                        hunt_hist <= hunt_nxt[6:0];
                        if (hunt_nxt == SYNC_PAT) begin
                            rx_state  <= COLLECT;
                            hunt_hist <= '0;
                            hb_cnt    <= '0;
                            blk_cnt   <= '0;
                        end
                    end
                end
                COLLECT: begin
                    if (hb_valid) begin
                        sreg <= sreg_nxt[BLOCK_W-2:0];
                        if (hb_cnt == HB_LAST) begin
                            hb_cnt     <= '0;
                            stage      <= sreg_nxt;
                            stage_vld  <= 1'b1;
                            stage_last <= (blk_cnt == LAST_IDX);
                            if (blk_cnt == LAST_IDX) begin
                                rx_state <= HUNT;
                                blk_cnt  <= '0;
                            end else begin
                                blk_cnt <= blk_cnt + 1'b1;
                            end
                        end else begin
                            hb_cnt <= hb_cnt + 1'b1;
                        end
                    end
                end
                default: rx_state <= HUNT;
            endcase

            // A block staged while the hold register is still occupied is lost.
            if (issue) begin
                hold_full <= 1'b0;
            end
            if (stage_vld) begin
                if (hold_drop) begin
                    err_overrun <= 1'b1;
                end else begin
                    hold      <= stage;
                    hold_last <= stage_last;
                    hold_full <= 1'b1;
                end
            end

            case (iss_state)
                ISSUE_IDLE: begin
                    if (hold_full) begin
                        dec_i_block  <= hold;
                        dec_valid_in <= 1'b1;
                        cur_last     <= hold_last;
                        tmo          <= '0;
                        iss_state    <= WAIT_DEC;
                    end
                end
                WAIT_DEC: begin
                    if (dec_valid_out) begin
                        iss_state <= ISSUE_IDLE;
                        if (push_ok) begin
                            if (cur_last) begin
                                frame_count <= frame_count + 16'd1;
                            end
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end else if (!tmo_hit) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: iss_state <= ISSUE_IDLE;
            endcase

            if (lock_now) begin
                locked <= 1'b1;
            end else if (last_end && (rx_state == HUNT)) begin
                locked <= 1'b0;
            end

            if (tmo_hit) begin
                err_timeout <= 1'b1;
                locked      <= 1'b0;
                rx_state    <= HUNT;
                iss_state   <= ISSUE_IDLE;
                hunt_hist   <= '0;
                sreg        <= '0;
                hb_cnt      <= '0;
                blk_cnt     <= '0;
                stage_vld   <= 1'b0;
                hold_full   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bmc_frame_sequencer.sv
// Directed bench for bmc_frame_sequencer with a fixed-latency echo model of bmc_decoder.
module tb_bmc_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        hb_in;
    logic        hb_valid;
    logic [23:0] dec_i_block;
    logic        dec_valid_in;
    logic [23:0] dec_o_block;
    logic        dec_valid_out;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        locked;
    logic        err_overrun;
    logic        err_timeout;
    logic [15:0] frame_count;

    int errors;
    int checks;

    int          dec_lat;
    int          dec_cnt;
    logic        dec_pend;
    logic [23:0] dec_buf;
    int          iss_cnt;
    logic [23:0] iss_log [16];
    int          viol;

    int          beat_cnt;
    logic [23:0] beat_data [16];
    logic        beat_last [16];

    bmc_frame_sequencer #(
        .SYNC_PAT    (8'hE8),
        .BLK_PER_FRM (4),
        .DEC_TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hb_in         (hb_in),
        .hb_valid      (hb_valid),
        .dec_i_block   (dec_i_block),
        .dec_valid_in  (dec_valid_in),
        .dec_o_block   (dec_o_block),
        .dec_valid_out (dec_valid_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .locked        (locked),
        .err_overrun   (err_overrun),
        .err_timeout   (err_timeout),
        .frame_count   (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: echoes each issued block dec_lat cycles later; dec_lat==0 never answers.
    initial begin
        dec_valid_out = 1'b0;
        dec_o_block   = '0;
        dec_pend      = 1'b0;
        dec_cnt       = 0;
        dec_buf       = '0;
        iss_cnt       = 0;
        viol          = 0;
        forever begin
            @(negedge clk);
            dec_valid_out = 1'b0;
            if (!rst_n) begin
                dec_pend = 1'b0;
                iss_cnt  = 0;
                viol     = 0;
            end else begin
                if (dec_pend && dec_cnt > 0) begin
                    dec_cnt = dec_cnt - 1;
                    if (dec_cnt == 0) begin
                        dec_valid_out = 1'b1;
                        dec_o_block   = dec_buf;
                        dec_pend      = 1'b0;
                    end
                end
                if (dec_valid_in) begin
                    if (dec_pend) viol = viol + 1;
                    if (iss_cnt < 16) iss_log[iss_cnt] = dec_i_block;
                    iss_cnt = iss_cnt + 1;
                    dec_buf = dec_i_block;
                    dec_pend = 1'b0;
                    if (dec_lat > 0) begin
                        dec_cnt = dec_lat - 1;
                        if (dec_cnt == 0) begin
                            dec_valid_out = 1'b1;
                            dec_o_block   = dec_buf;
                        end else begin
                            dec_pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Consumer monitor: records every accepted beat.
    initial begin
        beat_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                beat_cnt = 0;
            end else if (m_valid && m_ready) begin
                if (beat_cnt < 16) begin
                    beat_data[beat_cnt] = m_data;
                    beat_last[beat_cnt] = m_last;
                end
                beat_cnt = beat_cnt + 1;
            end
        end
    end

    task automatic do_reset();
        hb_in    = 1'b0;
        hb_valid = 1'b0;
        m_ready  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            hb_in    = v[i];
            hb_valid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            hb_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [23:0] b0, input logic [23:0] b1,
                              input logic [23:0] b2, input logic [23:0] b3);
        send_bits(24'hE8, 8);
        send_bits(b0, 24);
        send_bits(b1, 24);
        send_bits(b2, 24);
        send_bits(b3, 24);
    endtask

    task automatic wait_beats(input int n, input int bound);
        int t;
        t = 0;
        while (beat_cnt < n && t < bound) begin
            @(negedge clk);
            hb_valid = 1'b0;
            t++;
        end
        idle(3);
        checks++;
        if (beat_cnt < n) begin
            errors++;
            $display("FAIL wait_beats: got %0d beats, expected %0d within %0d cycles", beat_cnt, n, bound);
        end
    endtask

    task automatic test_reset();
        logic [69:0] outs;
        do_reset();
        outs = {dec_i_block, dec_valid_in, m_data, m_valid, m_last, locked,
                err_overrun, err_timeout, frame_count};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected all zero", outs);
        end
    endtask

    task automatic test_frame();
        int bad;
        logic [3:0] lastv;
        do_reset();
        m_ready = 1'b1;
        dec_lat = 3;
        send_frame(24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        wait_beats(4, 300);
        checks++;
        if (iss_cnt !== 4) begin
            errors++; $display("FAIL frame_issue_count: got %0d expected 4", iss_cnt);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (iss_log[i] !== 24'hFFFF00) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL frame_issue_data: %0d blocks differ from ffff00", bad);
        end
        bad = 0;
        lastv = '0;
        for (int i = 0; i < 4; i++) begin
            if (beat_data[i] !== 24'hFFFF00) bad++;
            lastv[i] = beat_last[i];
        end
        checks++;
        if (beat_cnt !== 4 || bad != 0) begin
            errors++; $display("FAIL frame_beats: count=%0d bad=%0d expected 4 beats of ffff00", beat_cnt, bad);
        end
        checks++;
        if (lastv !== 4'b1000) begin
            errors++; $display("FAIL frame_last: got %b expected 1000", lastv);
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++; $display("FAIL frame_count: got %0d expected 1", frame_count);
        end
        checks++;
        if (locked !== 1'b0 || err_overrun !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL frame_flags: locked=%b ovr=%b tmo=%b expected 0 0 0",
                               locked, err_overrun, err_timeout);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL frame_one_outstanding: %0d issues while waiting", viol);
        end
    endtask

    task automatic test_hunt();
        do_reset();
        m_ready = 1'b1;
        dec_lat = 3;
        send_bits(24'hE9, 8);
        send_bits(24'hE8, 8);
        checks++;
        if (locked !== 1'b0 || iss_cnt !== 0) begin
            errors++; $display("FAIL hunt_before_lock: locked=%b issues=%0d expected 0 0", locked, iss_cnt);
        end
        idle(1);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL hunt_lock_rise: locked=%b expected 1", locked);
        end
        send_bits(24'hFFFF00, 24);
        idle(1);
        checks++;
        if (dec_valid_in !== 1'b0) begin
            errors++; $display("FAIL hunt_issue_early1: dec_valid_in=%b expected 0", dec_valid_in);
        end
        idle(1);
        checks++;
        if (dec_valid_in !== 1'b0) begin
            errors++; $display("FAIL hunt_issue_early2: dec_valid_in=%b expected 0", dec_valid_in);
        end
        idle(1);
        checks++;
        if (dec_valid_in !== 1'b1 || dec_i_block !== 24'hFFFF00) begin
            errors++; $display("FAIL hunt_issue: dec_valid_in=%b block=%h expected 1 ffff00",
                               dec_valid_in, dec_i_block);
        end
        idle(1);
        checks++;
        if (dec_valid_in !== 1'b0) begin
            errors++; $display("FAIL hunt_issue_pulse: dec_valid_in=%b expected 0", dec_valid_in);
        end
        idle(1);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL hunt_mvalid_early: m_valid=%b expected 0", m_valid);
        end
        idle(1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 24'hFFFF00 || m_last !== 1'b0) begin
            errors++; $display("FAIL hunt_mvalid: m_valid=%b data=%h last=%b expected 1 ffff00 0",
                               m_valid, m_data, m_last);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] lastv;
        do_reset();
        m_ready = 1'b1;
        dec_lat = 0;
        send_bits(24'hE8, 8);
        send_bits(24'hFFFF00, 24);
        idle(66);
        checks++;
        if (err_timeout !== 1'b0 || locked !== 1'b1) begin
            errors++; $display("FAIL timeout_early: tmo=%b locked=%b expected 0 1", err_timeout, locked);
        end
        idle(1);
        checks++;
        if (err_timeout !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL timeout_hit: tmo=%b locked=%b expected 1 0", err_timeout, locked);
        end
        dec_lat = 3;
        send_frame(24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        wait_beats(4, 300);
        lastv = '0;
        for (int i = 0; i < 4; i++) lastv[i] = beat_last[i];
        checks++;
        if (beat_cnt !== 4 || lastv !== 4'b1000 || iss_cnt !== 5) begin
            errors++; $display("FAIL timeout_recover: beats=%0d last=%b issues=%0d expected 4 1000 5",
                               beat_cnt, lastv, iss_cnt);
        end
        checks++;
        if (frame_count !== 16'd1 || err_timeout !== 1'b1 || err_overrun !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky: frames=%0d tmo=%b ovr=%b expected 1 1 0",
                               frame_count, err_timeout, err_overrun);
        end
    endtask

    task automatic test_decoder_overrun();
        logic [2:0] lastv;
        do_reset();
        m_ready = 1'b1;
        dec_lat = 40;
        send_frame(24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        wait_beats(3, 300);
        idle(100);
        lastv = '0;
        for (int i = 0; i < 3; i++) lastv[i] = beat_last[i];
        checks++;
        if (iss_cnt !== 3 || beat_cnt !== 3) begin
            errors++; $display("FAIL ovr_counts: issues=%0d beats=%0d expected 3 3", iss_cnt, beat_cnt);
        end
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_flag: err_overrun=%b expected 1", err_overrun);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL ovr_one_outstanding: %0d issues while waiting", viol);
        end
        checks++;
        if (lastv !== 3'b000 || frame_count !== 16'd0 || locked !== 1'b0) begin
            errors++; $display("FAIL ovr_frame: last=%b frames=%0d locked=%b expected 000 0 0",
                               lastv, frame_count, locked);
        end
    endtask

    task automatic test_buffer_full();
        int bad;
        do_reset();
        m_ready = 1'b0;
        dec_lat = 3;
        send_frame(24'h123456, 24'hABCDEF, 24'h5A5A5A, 24'h0F0F0F);
        idle(20);
        checks++;
        if (iss_cnt !== 4 || err_overrun !== 1'b1) begin
            errors++; $display("FAIL buf_overrun: issues=%0d ovr=%b expected 4 1", iss_cnt, err_overrun);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 24'h123456 || m_last !== 1'b0) begin
            errors++; $display("FAIL buf_head: valid=%b data=%h last=%b expected 1 123456 0",
                               m_valid, m_data, m_last);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (m_data !== 24'h123456 || m_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL buf_stable: %0d cycles with head not 123456", bad);
        end
        @(negedge clk);
        m_ready = 1'b1;
        idle(10);
        checks++;
        if (beat_cnt !== 2 || beat_data[0] !== 24'h123456 || beat_data[1] !== 24'hABCDEF) begin
            errors++; $display("FAIL buf_drain: beats=%0d d0=%h d1=%h expected 2 123456 abcdef",
                               beat_cnt, beat_data[0], beat_data[1]);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL buf_empty: m_valid=%b expected 0", m_valid);
        end
    endtask

    task automatic test_async_reset();
        logic [69:0] outs;
        do_reset();
        m_ready = 1'b0;
        dec_lat = 3;
        send_bits(24'hE8, 8);
        send_bits(24'hFFFF00, 24);
        send_bits(24'h3FF, 10);
        checks++;
        if (locked !== 1'b1 || m_valid !== 1'b1) begin
            errors++; $display("FAIL arst_pre: locked=%b m_valid=%b expected 1 1", locked, m_valid);
        end
        @(negedge clk);
        hb_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        outs = {dec_i_block, dec_valid_in, m_data, m_valid, m_last, locked,
                err_overrun, err_timeout, frame_count};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL arst_outputs: got %h expected all zero", outs);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        send_bits(24'hFFFF00, 24);
        idle(10);
        checks++;
        if (iss_cnt !== 0 || locked !== 1'b0) begin
            errors++; $display("FAIL arst_rehunt: issues=%0d locked=%b expected 0 0", iss_cnt, locked);
        end
        send_frame(24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        wait_beats(4, 300);
        checks++;
        if (beat_cnt !== 4 || frame_count !== 16'd1) begin
            errors++; $display("FAIL arst_frame: beats=%0d frames=%0d expected 4 1", beat_cnt, frame_count);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        dec_lat  = 3;
        rst_n    = 1'b0;
        hb_in    = 1'b0;
        hb_valid = 1'b0;
        m_ready  = 1'b0;
        test_reset();
        test_frame();
        test_hunt();
        test_timeout();
        test_decoder_overrun();
        test_buffer_full();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
